spi_master_arb: RTL and testbench
=================================

// Module: spi_master_arb
// PURPOSE
//   SPI master shared between NREQ on-chip requesters, one slave per requester.
//   Round-robin arbitration picks one pending request at a time. The master generates sclk from clk.
//   It runs one 8-bit full-duplex transfer (mode 0, MSB first) on the selected chip select.
//   Sits between the local command logic and the spi_slave-style peripherals on the board bus.
// PARAMETERS
//   NREQ     2  number of requesters / chip selects (>=2)
//   CLK_DIV  2  clk cycles per sclk half-period (>=1)
// PORTS
//   clk          in   1        system clock
//   rst          in   1        synchronous reset, active-high
//   req          in   NREQ     request per requester; hold high until done bit
//   req_tx_data  in   8*NREQ   tx byte of requester i at [8*i+7:8*i]; stable while req high
//   gnt          out  NREQ     one-hot, high for the whole transfer of the granted requester
//   done         out  NREQ     one-cycle pulse to the granted requester at end of transfer
//   rx_data      out  8        byte received from miso; valid in the done cycle, held after
//   busy         out  1        high from grant cycle through done cycle
//   sclk         out  1        SPI clock, idles low
//   cs_n         out  NREQ     active-low chip selects, at most one low
//   mosi         out  1        serial data to slave
//   miso         in   1        serial data from slave
// BEHAVIOUR
//   Reset (any cycle, including mid-transfer), effective next edge:
//     cs_n all 1; sclk 0; mosi 0; gnt 0; done 0; busy 0; rx_data 0.
//     Round-robin pointer = NREQ-1, so requester 0 has priority first.
//     An aborted transfer produces no done pulse.
//   FSM states: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> DONE -> IDLE.
//   IDLE:
//     - If any req is high, grant the first set req searching from pointer+1 (wrapping).
//     - Set gnt/busy, latch that requester's tx byte into the shift register, update pointer.
//     - Drive mosi = bit 7 and go to SETUP.
//     - With no req set, stay in IDLE with all outputs at idle values.
//   SETUP: cs_n[granted] = 0, sclk = 0, for CLK_DIV cycles.
//   SHIFT_HI: sclk = 1 for CLK_DIV cycles.
//     - The slave samples mosi on the rising edge.
//     - In the last cycle of the state, the master samples miso into the rx shift register (LSB in).
//   SHIFT_LO: sclk = 0 for CLK_DIV cycles.
//     - On entry, mosi moves to the next lower bit.
//     - After the 8th bit, the state acts as the cs hold time, then goes to DONE.
//   DONE (1 cycle):
//     - cs_n all 1, rx_data updated from the shift register, done[granted] = 1.
//     - gnt cleared at the end of the cycle; busy still 1.
//   Timing:
//     - cs_n low for 17*CLK_DIV cycles.
//     - req-to-cs_n-low latency is 1 cycle.
//     - cs_n high between back-to-back transfers is at least 2 cycles (DONE + IDLE).
//   Bit counter is 3 bits and counts 7..0; no wrap beyond 0.
//   Half-period counter is sized clog2(CLK_DIV)+1.
//   req deasserted mid-transfer: ignored; the transfer completes and done still pulses.
//   req still high in the cycle after done: treated as a new request, arbitrated normally.
//   New reqs arriving during a transfer wait; they never preempt.
//   mosi returns to 0 in DONE and IDLE.
// TESTING (NREQ=2, CLK_DIV=2 unless stated)
//   1. req[0]=1, tx=8'hA5, slave model shifts out 8'h3C:
//      mosi on sclk rises = 1,0,1,0,0,1,0,1; done[0] pulses once; rx_data=8'h3C;
//      cs_n[0] low exactly 34 cycles; cs_n[1] stays 1.
//   2. req=2'b11 in the same cycle after reset, tx0=8'h11, tx1=8'h22:
//      requester 0 served first, then requester 1.
//      cs_n high exactly 2 cycles between the transfers; gnt 2'b01 then 2'b10.
//   3. req held at 2'b11 for 4 transfers: grants alternate 0,1,0,1; never two cs_n low together.
//   4. rst asserted while SHIFT_HI of bit 4:
//      next cycle cs_n=2'b11, sclk=0, busy=0, no done.
//      A fresh req[1] then transfers correctly.
//   5. req[1] dropped after the 3rd sclk rise: transfer finishes full 8 bits and done[1] pulses.
//   6. CLK_DIV=1, tx=8'hFF, miso=0: sclk period 2 clk; cs_n low 17 cycles; rx_data=8'h00.

Source files
------------

// File: rtl/spi_master_arb.sv
// spi_master_arb: one SPI master shared by NREQ requesters, one slave each.
// A round-robin arbiter picks one pending request, then an 8-bit mode-0
// full-duplex transfer (MSB first) runs on that requester's chip select.
// sclk is derived from clk with CLK_DIV clk cycles per half-period.
module spi_master_arb #(
    parameter int NREQ    = 2,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_tx_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rx_data,
    output logic              busy,
    output logic              sclk,
    output logic [NREQ-1:0]   cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_txShift;
    logic [7:0]        r_rxShift;
    logic [7:0]        r_rxData;
    logic              r_mosi;
    logic [NREQ-1:0]   r_gnt;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_gntIdx;
    logic [NREQ-1:0]   w_gntOneHot;
    logic [7:0]        w_txByte;
    logic              w_found;
    logic              w_halfEnd;

    assign w_halfEnd = (r_cnt == CNT_LAST);
    assign gnt       = r_gnt;
    assign rx_data   = r_rxData;
    assign mosi      = r_mosi;

    // Round-robin search: first pending request after the last one served.
    always_comb begin
        int idx;
        idx         = 0;
        w_found     = 1'b0;
        w_gntIdx    = '0;
        w_gntOneHot = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_gntIdx = PW'(idx);
            end
        end
        if (w_found) begin
            w_gntOneHot[w_gntIdx] = 1'b1;
        end
        w_txByte = req_tx_data[{w_gntIdx, 3'b000} +: 8];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the state-decoded bus outputs.
    always_comb begin
        w_nextState = r_state;
        sclk        = 1'b0;
        cs_n        = '1;
        busy        = 1'b1;
        done        = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_nextState = SETUP;
                end
            end
            SETUP: begin
                cs_n = ~r_gnt;
                if (w_halfEnd) begin
                    w_nextState = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                cs_n = ~r_gnt;
                sclk = 1'b1;
                if (w_halfEnd) begin
                    w_nextState = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                cs_n = ~r_gnt;
                if (w_halfEnd) begin
                    w_nextState = (r_bit == 3'd0) ? DONE : SHIFT_HI;
                end
            end
            DONE: begin
                done        = r_gnt;
                w_nextState = IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_nextState = IDLE;
            end
        endcase
    end

    // Half-period timer: restarts whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE || r_state != w_nextState) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Grant capture, shift registers, bit counter and received byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_ptr     <= PW'(NREQ - 1);
            r_txShift <= '0;
            r_rxShift <= '0;
            r_rxData  <= '0;
            r_mosi    <= 1'b0;
            r_bit     <= 3'd7;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt     <= w_gntOneHot;
                        r_ptr     <= w_gntIdx;
                        r_txShift <= w_txByte;
                        r_mosi    <= w_txByte[7];
                        r_bit     <= 3'd7;
                    end
                end
                SHIFT_HI: begin
                    if (w_halfEnd) begin
                        r_rxShift <= {r_rxShift[6:0], miso};
                        if (r_bit != 3'd0) begin
                            r_mosi <= r_txShift[r_bit - 3'd1];
                        end
                    end
                end
                SHIFT_LO: begin
                    if (w_halfEnd) begin
                        if (r_bit == 3'd0) begin
                            r_rxData <= r_rxShift;
                            r_mosi   <= 1'b0;
                        end else begin
                            r_bit <= r_bit - 3'd1;
                        end
                    end
                end
                DONE: begin
                    r_gnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed self-checking bench for spi_master_arb: instance A uses
// CLK_DIV=2, instance B uses CLK_DIV=1; both have two requesters.
module tb_spi_master_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [1:0]  reqA = '0, reqB = '0;
    logic [15:0] txA = '0, txB = '0;
    logic [1:0]  gntA, doneA, csNA, gntB, doneB, csNB;
    logic [7:0]  rxA, rxB;
    logic        busyA, sclkA, mosiA, misoA, busyB, sclkB, mosiB;
    logic        misoB = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_master_arb #(.NREQ(2), .CLK_DIV(2)) dutA (
        .clk(clk), .rst(rst), .req(reqA), .req_tx_data(txA), .gnt(gntA),
        .done(doneA), .rx_data(rxA), .busy(busyA), .sclk(sclkA),
        .cs_n(csNA), .mosi(mosiA), .miso(misoA)
    );

    spi_master_arb #(.NREQ(2), .CLK_DIV(1)) dutB (
        .clk(clk), .rst(rst), .req(reqB), .req_tx_data(txB), .gnt(gntB),
        .done(doneB), .rx_data(rxB), .busy(busyB), .sclk(sclkB),
        .cs_n(csNB), .mosi(mosiB), .miso(misoB)
    );

    // Slave model for A: presents byte MSB first, next bit after each sclk rise.
    logic [7:0] slaveByte = 8'h00;
    logic [7:0] mosiLogA = '0, mosiLogB = '0;
    int sclkRisesA = 0, risesAtCsA = 0;
    wire csAllA = &csNA;

    function automatic logic misoBit(input logic [7:0] b, input int rel);
        if (rel >= 1 && rel <= 8) return b[8 - rel];
        return 1'b0;
    endfunction

    assign misoA = misoBit(slaveByte, sclkRisesA - risesAtCsA);

    always @(posedge sclkA) begin
        sclkRisesA <= sclkRisesA + 1;
        mosiLogA   <= {mosiLogA[6:0], mosiA};
    end

    always @(negedge csAllA) risesAtCsA <= sclkRisesA;

    always @(posedge sclkB) mosiLogB <= {mosiLogB[6:0], mosiB};

    // Bus monitors sampled on the falling clock edge.
    int lowRunA = 0, lastLowRunA = 0, highRunA = 0, lastHighRunA = 0;
    int doneCntA = 0, cs1LowA = 0;
    logic bothLowA = 1'b0;
    logic [1:0] gntPrevA = '0, lastGntA = '0, prevGntA = '0;
    int lowRunB = 0, lastLowRunB = 0, sclkHighB = 0;

    always @(negedge clk) begin
        if (csNA != 2'b11) begin
            lowRunA  <= lowRunA + 1;
            highRunA <= 0;
            if (highRunA != 0) lastHighRunA <= highRunA;
        end else begin
            highRunA <= highRunA + 1;
            lowRunA  <= 0;
            if (lowRunA != 0) lastLowRunA <= lowRunA;
        end
        if (doneA != 2'b00) doneCntA <= doneCntA + 1;
        if (csNA == 2'b00) bothLowA <= 1'b1;
        if (!csNA[1]) cs1LowA <= cs1LowA + 1;
        if (gntA != 2'b00 && gntA != gntPrevA) begin
            prevGntA <= lastGntA;
            lastGntA <= gntA;
        end
        gntPrevA <= gntA;
    end

    always @(negedge clk) begin
        if (csNB != 2'b11) begin
            lowRunB <= lowRunB + 1;
        end else begin
            lowRunB <= 0;
            if (lowRunB != 0) lastLowRunB <= lowRunB;
        end
        if (sclkB) sclkHighB <= sclkHighB + 1;
    end

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitDone(input bit useB, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            if ((useB ? doneB : doneA) != 2'b00) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no done pulse, required one within 300 cycles", name);
        end
    endtask

    task automatic waitRises(input int target, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (sclkRisesA - base >= target) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL rises_timeout: got %0d sclk rises, required %0d", sclkRisesA - base, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (csNA !== 2'b11) begin errors++; $display("[TB] FAIL reset_csn: got %b required 11", csNA); end
        checks++; if (sclkA !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b required 0", sclkA); end
        checks++; if (mosiA !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b required 0", mosiA); end
        checks++; if (gntA !== 2'b00 || doneA !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt_done: got %b/%b required 00/00", gntA, doneA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busyA); end
        checks++; if (rxA !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx: got %h required 00", rxA); end
        checks++; if (csNB !== 2'b11 || busyB !== 1'b0) begin errors++; $display("[TB] FAIL reset_b: got cs_n=%b busy=%b required 11/0", csNB, busyB); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busyA !== 1'b0 || csNA !== 2'b11) begin errors++; $display("[TB] FAIL idle_no_req: got busy=%b cs_n=%b required 0/11", busyA, csNA); end
    endtask

    task automatic test_single();
        bit ok;
        int d0, c0;
        slaveByte = 8'h3C;
        txA = 16'h00A5;
        d0 = doneCntA;
        c0 = cs1LowA;
        @(negedge clk);
        reqA = 2'b01;
        @(negedge clk);
        #1;
        checks++; if (csNA !== 2'b10) begin errors++; $display("[TB] FAIL single_latency: got cs_n=%b required 10", csNA); end
        checks++; if (gntA !== 2'b01 || busyA !== 1'b1) begin errors++; $display("[TB] FAIL single_grant: got gnt=%b busy=%b required 01/1", gntA, busyA); end
        waitDone(1'b0, "single", ok);
        reqA = 2'b00;
        checks++; if (doneA !== 2'b01) begin errors++; $display("[TB] FAIL single_done: got %b required 01", doneA); end
        checks++; if (rxA !== 8'h3C) begin errors++; $display("[TB] FAIL single_rx: got %h required 3c", rxA); end
        checks++; if (mosiLogA !== 8'hA5) begin errors++; $display("[TB] FAIL single_mosi: got %h required a5", mosiLogA); end
        checks++; if (lastLowRunA != 34) begin errors++; $display("[TB] FAIL single_cs_low: got %0d cycles required 34", lastLowRunA); end
        checks++; if (busyA !== 1'b1 || csNA !== 2'b11) begin errors++; $display("[TB] FAIL single_done_cycle: got busy=%b cs_n=%b required 1/11", busyA, csNA); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (doneCntA - d0 != 1) begin errors++; $display("[TB] FAIL single_done_count: got %0d required 1", doneCntA - d0); end
        checks++; if (cs1LowA - c0 != 0) begin errors++; $display("[TB] FAIL single_cs1: got %0d low cycles required 0", cs1LowA - c0); end
        checks++; if (rxA !== 8'h3C || busyA !== 1'b0 || mosiA !== 1'b0) begin errors++; $display("[TB] FAIL single_after: got rx=%h busy=%b mosi=%b required 3c/0/0", rxA, busyA, mosiA); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        doReset();
        slaveByte = 8'h5A;
        txA = {8'h22, 8'h11};
        reqA = 2'b11;
        waitDone(1'b0, "b2b_first", ok);
        reqA = 2'b10;
        checks++; if (doneA !== 2'b01) begin errors++; $display("[TB] FAIL b2b_first_done: got %b required 01", doneA); end
        checks++; if (mosiLogA !== 8'h11) begin errors++; $display("[TB] FAIL b2b_first_mosi: got %h required 11", mosiLogA); end
        waitDone(1'b0, "b2b_second", ok);
        reqA = 2'b00;
        checks++; if (doneA !== 2'b10) begin errors++; $display("[TB] FAIL b2b_second_done: got %b required 10", doneA); end
        checks++; if (mosiLogA !== 8'h22 || rxA !== 8'h5A) begin errors++; $display("[TB] FAIL b2b_second_data: got mosi=%h rx=%h required 22/5a", mosiLogA, rxA); end
        checks++; if (lastHighRunA != 2) begin errors++; $display("[TB] FAIL b2b_gap: got %0d cs_n high cycles required 2", lastHighRunA); end
        checks++; if (prevGntA !== 2'b01 || lastGntA !== 2'b10) begin errors++; $display("[TB] FAIL b2b_gnt_order: got %b then %b required 01 then 10", prevGntA, lastGntA); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_alternate();
        bit ok;
        logic [1:0] expDone;
        doReset();
        slaveByte = 8'h81;
        txA = {8'h0F, 8'hF0};
        reqA = 2'b11;
        for (int i = 0; i < 4; i++) begin
            waitDone(1'b0, "alt", ok);
            if (i == 3) reqA = 2'b00;
            expDone = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (doneA !== expDone) begin errors++; $display("[TB] FAIL alt_done_%0d: got %b required %b", i, doneA, expDone); end
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bothLowA !== 1'b0) begin errors++; $display("[TB] FAIL alt_cs_exclusive: got both low=%b required 0", bothLowA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL alt_end_idle: got busy=%b required 0", busyA); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0, d0;
        doReset();
        slaveByte = 8'h96;
        txA = {8'hC3, 8'hA5};
        reqA = 2'b01;
        r0 = sclkRisesA;
        waitRises(4, r0, ok);
        checks++; if (sclkA !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_high: got sclk=%b required 1", sclkA); end
        d0 = doneCntA;
        rst = 1'b1;
        reqA = 2'b00;
        @(negedge clk);
        #1;
        checks++; if (csNA !== 2'b11 || sclkA !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_bus: got cs_n=%b sclk=%b required 11/0", csNA, sclkA); end
        checks++; if (busyA !== 1'b0 || doneA !== 2'b00 || gntA !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_ctrl: got busy=%b done=%b gnt=%b required 0/00/00", busyA, doneA, gntA); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (doneCntA != d0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d done pulses required 0", doneCntA - d0); end
        reqA = 2'b10;
        waitDone(1'b0, "mid_fresh", ok);
        reqA = 2'b00;
        checks++; if (doneA !== 2'b10 || rxA !== 8'h96) begin errors++; $display("[TB] FAIL mid_fresh: got done=%b rx=%h required 10/96", doneA, rxA); end
        checks++; if (mosiLogA !== 8'hC3 || lastLowRunA != 34) begin errors++; $display("[TB] FAIL mid_fresh_bus: got mosi=%h cs_low=%0d required c3/34", mosiLogA, lastLowRunA); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_drop_req();
        bit ok;
        int r0, d0;
        slaveByte = 8'hE7;
        txA = {8'h5A, 8'h00};
        d0 = doneCntA;
        reqA = 2'b10;
        r0 = sclkRisesA;
        waitRises(3, r0, ok);
        reqA = 2'b00;
        waitDone(1'b0, "drop", ok);
        checks++; if (doneA !== 2'b10) begin errors++; $display("[TB] FAIL drop_done: got %b required 10", doneA); end
        checks++; if (mosiLogA !== 8'h5A || rxA !== 8'hE7) begin errors++; $display("[TB] FAIL drop_data: got mosi=%h rx=%h required 5a/e7", mosiLogA, rxA); end
        checks++; if (sclkRisesA - r0 != 8 || lastLowRunA != 34) begin errors++; $display("[TB] FAIL drop_full: got rises=%0d cs_low=%0d required 8/34", sclkRisesA - r0, lastLowRunA); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (doneCntA - d0 != 1) begin errors++; $display("[TB] FAIL drop_done_count: got %0d required 1", doneCntA - d0); end
    endtask

    task automatic test_clkdiv1();
        bit ok;
        int h0;
        txB = 16'h00FF;
        h0 = sclkHighB;
        @(negedge clk);
        reqB = 2'b01;
        @(negedge clk);
        #1;
        checks++; if (csNB !== 2'b10) begin errors++; $display("[TB] FAIL div1_latency: got cs_n=%b required 10", csNB); end
        waitDone(1'b1, "div1", ok);
        reqB = 2'b00;
        checks++; if (doneB !== 2'b01 || rxB !== 8'h00) begin errors++; $display("[TB] FAIL div1_done: got done=%b rx=%h required 01/00", doneB, rxB); end
        checks++; if (lastLowRunB != 17) begin errors++; $display("[TB] FAIL div1_cs_low: got %0d cycles required 17", lastLowRunB); end
        checks++; if (sclkHighB - h0 != 8) begin errors++; $display("[TB] FAIL div1_sclk: got %0d high cycles required 8", sclkHighB - h0); end
        checks++; if (mosiLogB !== 8'hFF) begin errors++; $display("[TB] FAIL div1_mosi: got %h required ff", mosiLogB); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_reset_mid();
        test_drop_req();
        test_clkdiv1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at 500000 time units, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
